laser_search_ctrl: RTL and testbench

//  Sequences the two-circle laser coverage search over the 16x16 grid. Owns the scan and iteration

---
 rtl/laser_pkg.sv | 19 +
 rtl/laser_tag_fifo.sv | 54 +++++
 rtl/laser_search_ctrl.sv | 170 +++++++++++++++++
 tb/tb_laser_search_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the two-circle laser coverage search.
package laser_pkg;
  localparam int COORD_W = 4;
  localparam int CNT_W   = 6;
  localparam int GRID_N  = 1 << COORD_W;
  localparam int NUM_PTS = 40;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_TRY1, S_SCAN2, S_SCAN1, S_EVAL, S_FIN
  } state_e;

  // States that walk the candidate grid and talk to the evaluator
  function automatic logic is_scan(state_e s);
    return (s == S_TRY1) || (s == S_SCAN2) || (s == S_SCAN1);
  endfunction
endpackage

// File: rtl/laser_tag_fifo.sv
// Sync FIFO remembering which candidate each in-flight evaluator request was for.
// Push and pop together are allowed when full or empty; when empty the written
// word falls straight through to rdata.
module laser_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          bypass, do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = empty ? wdata : mem_q[rptr_q];

  // Pointer / occupancy / storage next-state
  always_comb begin
    bypass  = empty && push && pop;
    do_push = push && (!full || pop) && !bypass;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wptr_q] = wdata;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // State registers, synchronous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/laser_search_ctrl.sv
// Two-circle coverage search sequencer: raster-scans candidates through an
// external in-order evaluator, keeps the best C1/C2, refines until converged.
module laser_search_ctrl import laser_pkg::*; #(
  parameter int CW       = COORD_W,
  parameter int NW       = CNT_W,
  parameter int MAX_ITER = 4,
  parameter int MAX_OUT  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  output logic          ev_req_valid,
  input  logic          ev_req_ready,
  output logic [CW-1:0] ev_c1x,
  output logic [CW-1:0] ev_c1y,
  output logic [CW-1:0] ev_c2x,
  output logic [CW-1:0] ev_c2y,
  input  logic          ev_rsp_valid,
  input  logic [NW-1:0] ev_rsp_cnt,
  output logic [CW-1:0] C1X,
  output logic [CW-1:0] C1Y,
  output logic [CW-1:0] C2X,
  output logic [CW-1:0] C2Y,
  output logic          DONE,
  output logic          busy,
  output logic          err
);
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int IW = $clog2(MAX_ITER) + 1;
  localparam int QW = 2*CW + 1;
  localparam logic [QW-1:0] NCAND = QW'(1) << (2*CW);

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [QW-1:0] issued_q, issued_d;
  logic [OW-1:0] out_q, out_d;
  logic [NW-1:0] best_num_q, best_num_d, snap_q, snap_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [CW-1:0] b1x_q, b1x_d, b1y_q, b1y_d, b2x_q, b2x_d, b2y_q, b2y_d;
  logic [CW-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic          err_q, err_d;

  logic [2*CW-1:0] tag;
  logic            tag_full, tag_empty;
  logic            xfer, rsp_ok, phase_done;

  // FIFO occupancy mirrors the registered outstanding count, so its flags
  // gate issue and response acceptance without any rsp->req combinational path.
  assign ev_req_valid = is_scan(state_q) && (issued_q < NCAND) && !tag_full;
  assign xfer         = ev_req_valid && ev_req_ready;
  assign rsp_ok       = ev_rsp_valid && !tag_empty;
  assign phase_done   = is_scan(state_q) && (issued_q == NCAND) && (out_q == '0);

  // Payload comes only from registers that cannot move during a stall
  assign ev_c1x = (state_q == S_SCAN2) ? b1x_q : x_q;
  assign ev_c1y = (state_q == S_SCAN2) ? b1y_q : y_q;
  assign ev_c2x = (state_q == S_SCAN1) ? b2x_q : x_q;
  assign ev_c2y = (state_q == S_SCAN1) ? b2y_q : y_q;

  assign C1X  = c1x_q;
  assign C1Y  = c1y_q;
  assign C2X  = c2x_q;
  assign C2Y  = c2y_q;
  assign DONE = (state_q == S_FIN);
  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

  laser_tag_fifo #(.DEPTH(MAX_OUT), .W(2*CW)) u_tags (
    .CLK(CLK), .RST(RST),
    .push(xfer), .wdata({x_q, y_q}),
    .pop(rsp_ok), .rdata(tag),
    .full(tag_full), .empty(tag_empty)
  );

  // Scan schedule, outstanding tracking, best-candidate tracking and FSM
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    issued_d   = issued_q;
    best_num_d = best_num_q;
    snap_d     = snap_q;
    iter_d     = iter_q;
    b1x_d = b1x_q; b1y_d = b1y_q; b2x_d = b2x_q; b2y_d = b2y_q;
    c1x_d = c1x_q; c1y_d = c1y_q; c2x_d = c2x_q; c2y_d = c2y_q;
    err_d      = err_q;

    // Raster with x fastest: {y,x} is a plain 2*CW-bit counter
    if (xfer) begin
      {y_d, x_d} = {y_q, x_q} + (2*CW)'(1);
      issued_d   = issued_q + QW'(1);
    end
    out_d = out_q + OW'(xfer) - OW'(rsp_ok);

    // >= so ties move to the later candidate; SCAN2 is the only C2 phase
    if (rsp_ok && (ev_rsp_cnt >= best_num_q)) begin
      best_num_d = ev_rsp_cnt;
      if (state_q == S_SCAN2) {b2x_d, b2y_d} = tag;
      else                    {b1x_d, b1y_d} = tag;
    end

    if (phase_done) begin
      x_d      = '0;
      y_d      = '0;
      issued_d = '0;
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_TRY1;
        best_num_d = '0;
        iter_d     = '0;
        b1x_d = '0; b1y_d = '0; b2x_d = '0; b2y_d = '0;
        err_d      = 1'b0;
      end
      S_TRY1: if (phase_done) begin
        state_d = S_SCAN2;
        b2x_d   = b1x_q;
        b2y_d   = b1y_q;
        snap_d  = best_num_q;
      end
      S_SCAN2: if (phase_done) state_d = S_SCAN1;
      S_SCAN1: if (phase_done) state_d = S_EVAL;
      S_EVAL: begin
        iter_d = iter_q + IW'(1);
        if ((iter_q == IW'(MAX_ITER-1)) || (best_num_q == snap_q)) begin
          state_d = S_FIN;
          c1x_d = b1x_q; c1y_d = b1y_q; c2x_d = b2x_q; c2y_d = b2y_q;
        end else begin
          state_d = S_SCAN2;
          snap_d  = best_num_q;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A response with nothing in flight is dropped and flagged
    if (ev_rsp_valid && tag_empty) err_d = 1'b1;
  end

  // State registers, synchronous active-high clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      issued_q   <= '0;
      out_q      <= '0;
      best_num_q <= '0;
      snap_q     <= '0;
      iter_q     <= '0;
      b1x_q <= '0; b1y_q <= '0; b2x_q <= '0; b2y_q <= '0;
      c1x_q <= '0; c1y_q <= '0; c2x_q <= '0; c2y_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      issued_q   <= issued_d;
      out_q      <= out_d;
      best_num_q <= best_num_d;
      snap_q     <= snap_d;
      iter_q     <= iter_d;
      b1x_q <= b1x_d; b1y_q <= b1y_d; b2x_q <= b2x_d; b2y_q <= b2y_d;
      c1x_q <= c1x_d; c1y_q <= c1y_d; c2x_q <= c2x_d; c2y_q <= c2y_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_laser_search_ctrl.sv
// Bench for laser_search_ctrl: randomized evaluator (ready/latency) computing
// coverage from a point set, checked against a loop-level model of the search.
module tb_laser_search_ctrl;
  import laser_pkg::*;

  localparam int RAD = 2;

  logic       CLK = 1'b0;
  logic       RST, start, ev_req_ready, ev_rsp_valid;
  logic [5:0] ev_rsp_cnt;
  logic       ev_req_valid, DONE, busy, err;
  logic [3:0] ev_c1x, ev_c1y, ev_c2x, ev_c2y, C1X, C1Y, C2X, C2Y;

  always #5 CLK = ~CLK;

  laser_search_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start),
    .ev_req_valid(ev_req_valid), .ev_req_ready(ev_req_ready),
    .ev_c1x(ev_c1x), .ev_c1y(ev_c1y), .ev_c2x(ev_c2x), .ev_c2y(ev_c2y),
    .ev_rsp_valid(ev_rsp_valid), .ev_rsp_cnt(ev_rsp_cnt),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .DONE(DONE), .busy(busy), .err(err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- evaluator environment ----------------
  int npts;
  int px[NUM_PTS], py[NUM_PTS];
  int ev_mode;   // 0: real coverage, 1: count grows with response index (never converges)
  int rdy_pct, lat_max;
  logic inj;

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int eval_cnt(int ax, int ay, int bx, int by, int idx);
    int c;
    if (ev_mode == 1) return ((idx >> 6) > 63) ? 63 : (idx >> 6);
    c = 0;
    for (int i = 0; i < npts; i++)
      if ((absi(px[i]-ax) <= RAD && absi(py[i]-ay) <= RAD) ||
          (absi(px[i]-bx) <= RAD && absi(py[i]-by) <= RAD)) c++;
    return c;
  endfunction

  typedef struct {int c1x; int c1y; int c2x; int c2y; int due;} req_t;
  req_t pq[$];
  int cyc = 0, rsp_idx = 0, tb_out = 0, max_out = 0;
  int xfer_cnt = 0, done_cnt = 0, stall_bad = 0;
  logic stall_prev = 1'b0;
  logic [15:0] stall_pl;

  // Bookkeeping on pre-edge values: accepted requests, outstanding, stalls
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      pq.delete();
      tb_out = 0;
      stall_prev = 1'b0;
    end else begin
      if (ev_rsp_valid && tb_out > 0) tb_out--;
      if (ev_req_valid && ev_req_ready) begin
        pq.push_back('{int'(ev_c1x), int'(ev_c1y), int'(ev_c2x), int'(ev_c2y),
                       cyc + int'($urandom_range(lat_max, 1)) - 1});
        tb_out++;
        xfer_cnt++;
      end
      if (tb_out > max_out) max_out = tb_out;
      if (DONE) done_cnt++;
      if (stall_prev && ev_req_valid && ({ev_c1x, ev_c1y, ev_c2x, ev_c2y} != stall_pl))
        stall_bad++;
      stall_prev = ev_req_valid && !ev_req_ready;
      stall_pl   = {ev_c1x, ev_c1y, ev_c2x, ev_c2y};
    end
  end

  // Drive evaluator inputs half a cycle away from the sampling edge
  always @(negedge CLK) begin
    req_t r;
    ev_req_ready = ($urandom_range(99) < rdy_pct);
    ev_rsp_valid = 1'b0;
    ev_rsp_cnt   = '0;
    if (inj) begin
      ev_rsp_valid = 1'b1;
      ev_rsp_cnt   = 6'd40;
      inj = 1'b0;
    end else if (pq.size() > 0 && pq[0].due <= cyc) begin
      r = pq.pop_front();
      ev_rsp_valid = 1'b1;
      ev_rsp_cnt   = 6'(eval_cnt(r.c1x, r.c1y, r.c2x, r.c2y, rsp_idx));
      rsp_idx++;
    end
  end

  // ---------------- reference model ----------------
  int m1x, m1y, m2x, m2y, m_iters;

  task automatic model();
    int best, idx, b1, b2, snap, c;
    best = 0; idx = 0; b1 = 0; b2 = 0;
    for (int k = 0; k < GRID_N*GRID_N; k++) begin
      c = eval_cnt(k % GRID_N, k / GRID_N, k % GRID_N, k / GRID_N, idx++);
      if (c >= best) begin best = c; b1 = k; end
    end
    b2 = b1;
    m_iters = 0;
    for (int it = 0; it < 4; it++) begin
      snap = best;
      m_iters = it + 1;
      for (int k = 0; k < GRID_N*GRID_N; k++) begin
        c = eval_cnt(b1 % GRID_N, b1 / GRID_N, k % GRID_N, k / GRID_N, idx++);
        if (c >= best) begin best = c; b2 = k; end
      end
      for (int k = 0; k < GRID_N*GRID_N; k++) begin
        c = eval_cnt(k % GRID_N, k / GRID_N, b2 % GRID_N, b2 / GRID_N, idx++);
        if (c >= best) begin best = c; b1 = k; end
      end
      if (best == snap) break;
    end
    m1x = b1 % GRID_N; m1y = b1 / GRID_N;
    m2x = b2 % GRID_N; m2y = b2 / GRID_N;
  endtask

  // ---------------- stimulus helpers ----------------
  // 20 points in a 5x5 box minus corners and centre: only the centre covers all
  task automatic add_cluster(input int cx, input int cy);
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        if (!((absi(dx) == 2 && absi(dy) == 2) || (dx == 0 && dy == 0))) begin
          px[npts] = cx + dx; py[npts] = cy + dy; npts++;
        end
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic clear_stats();
    xfer_cnt = 0; rsp_idx = 0; done_cnt = 0; max_out = 0; stall_bad = 0;
  endtask

  task automatic run_search(input string tag, input bit restart_mid);
    bit got;
    model();
    @(negedge CLK);
    clear_stats();
    pulse_start();
    chk({tag, "_err_clr"}, err, 0);
    if (restart_mid) begin
      repeat (100) @(negedge CLK);
      start = 1'b1;
      @(negedge CLK); start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin got = 1; break; end
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      chk({tag, "_c1"}, {C1X, C1Y}, {4'(m1x), 4'(m1y)});
      chk({tag, "_c2"}, {C2X, C2Y}, {4'(m2x), 4'(m2y)});
      chk({tag, "_busy_at_done"}, busy, 1);
      chk({tag, "_requests"}, xfer_cnt, 256 * (1 + 2*m_iters));
      chk({tag, "_max_out"}, max_out <= 4, 1);
      chk({tag, "_stall_stable"}, stall_bad, 0);
      @(posedge CLK); #1;
      chk({tag, "_done_1cyc"}, {DONE, busy}, 2'b00);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    RST = 1'b1; start = 1'b0; inj = 1'b0;
    rdy_pct = 100; lat_max = 1; ev_mode = 0; npts = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", {ev_req_valid, busy, DONE, err, C1X, C1Y, C2X, C2Y,
                       ev_c1x, ev_c1y, ev_c2x, ev_c2y}, 0);
    @(negedge CLK); RST = 1'b0;

    // One cluster: C1 must land on its unique centre, converges after 1 iteration
    npts = 0; add_cluster(5, 5);
    run_search("one_cluster", 0);
    chk("one_cluster_c1_const", {C1X, C1Y}, {4'd5, 4'd5});
    chk("one_cluster_reqs_const", xfer_cnt, 768);

    // Two clusters, with a start pulse mid-search that must be ignored
    npts = 0; add_cluster(3, 3); add_cluster(12, 12);
    run_search("two_cluster", 1);
    chk("two_cluster_set", ({C1X, C1Y, C2X, C2Y} == 16'h33CC) ||
                           ({C1X, C1Y, C2X, C2Y} == 16'hCC33), 1);

    // Random ready and latency, same point set
    rdy_pct = 50; lat_max = 6;
    run_search("two_cluster_rnd", 0);
    chk("two_cluster_rnd_set", ({C1X, C1Y, C2X, C2Y} == 16'h33CC) ||
                               ({C1X, C1Y, C2X, C2Y} == 16'hCC33), 1);

    // Random point cloud under random handshake
    npts = NUM_PTS;
    for (int i = 0; i < NUM_PTS; i++) begin
      px[i] = int'($urandom_range(GRID_N-1));
      py[i] = int'($urandom_range(GRID_N-1));
    end
    run_search("rand_pts", 0);

    // Unexpected response while idle: err sticky, result untouched
    rdy_pct = 100; lat_max = 1;
    @(posedge CLK); #1; inj = 1'b1;
    @(posedge CLK); #1;
    chk("inj_err", err, 1);
    chk("inj_result_held", {C1X, C1Y, C2X, C2Y}, {4'(m1x), 4'(m1y), 4'(m2x), 4'(m2y)});
    @(posedge CLK); #1;
    chk("inj_err_sticky", err, 1);
    run_search("after_inj", 0);

    // Reset during SCAN1 aborts with no DONE; restart is clean
    npts = 0; add_cluster(3, 3); add_cluster(12, 12);
    lat_max = 3;
    @(negedge CLK); clear_stats();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #1;
      if (xfer_cnt >= 560) begin ok = 1; break; end
    end
    chk("rst_mid_reach_scan1", ok, 1);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_outs", {ev_req_valid, busy, DONE, err, C1X, C1Y, C2X, C2Y,
                         ev_c1x, ev_c1y, ev_c2x, ev_c2y}, 0);
    @(negedge CLK); RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_idle", {busy, ev_req_valid}, 0);
    run_search("after_rst", 0);

    // Evaluator that keeps improving: runs the full iteration budget
    ev_mode = 1;
    run_search("nonconv", 0);
    chk("nonconv_reqs_const", xfer_cnt, 2304);
    chk("nonconv_c1_const", {C1X, C1Y}, {4'd15, 4'd15});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
